imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Registered, parametrised immediate generator for the decode stage. It extracts and extends the immediate of every RV32I/RV64I format, including the U-type, CSR zimm and shift-amount forms. Each result travels with a sideband tag through a valid/ready handshake backed by a 2-entry skid buffer, so execute-stage stalls never create a combinational ready path back into fetch/decode. It replaces the combinational extender between the instruction register and the ALU source mux.

## Interface

Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64.
- TAG_W, 32: width of the sideband tag carried with each instruction (PC, rd, etc.).

Ports:
- i_immgen_clk  in  1  single clock.
- i_immgen_rst  in  1  reset: synchronous, active-high.
- i_immgen_valid  in  1  upstream has an instruction.
- o_immgen_ready  out  1  block can accept.
- i_immgen_Instr  in  [31:7]  instruction bits.
- i_immgen_ImmSrc  in  3  format select (imm_src_e).
- i_immgen_Tag  in  TAG_W  sideband, passed through unchanged.
- o_immgen_valid  out  1  output holds a result.
- i_immgen_ready  in  1  downstream accepts.
- o_immgen_ImmExt  out  XLEN  extended immediate.
- o_immgen_Tag  out  TAG_W  tag matching o_immgen_ImmExt.
- o_immgen_Illegal  out  1  format reserved or illegal for XLEN.

## Operation

Formats (S = Instr[31], sign-extended to XLEN unless noted):
- 000 I: Instr[31:20].
- 001 S: {Instr[31:25], Instr[11:7]}.
- 010 B: {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}.
- 011 J: {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}.
- 100 U: {Instr[31:12], 12'b0}, sign-extended from bit 31 when XLEN=64.
- 101 Z: Instr[19:15], zero-extended (CSR zimm).
- 110 SH: XLEN=32 gives Instr[24:20] zero-extended, with Illegal=1 when Instr[25]=1. XLEN=64 gives Instr[25:20] zero-extended and is never illegal.
- 111 reserved: ImmExt=0, Illegal=1.

Buffering:
- Two entries: output register (OUT) and skid register (SKID).
- Accept = i_immgen_valid & o_immgen_ready.
- o_immgen_ready = !SKID.valid. It is a registered term only and has no path from i_immgen_ready.
- Pop = o_immgen_valid & i_immgen_ready.
- Accept into OUT when OUT is empty or being popped and SKID is empty. Otherwise the accepted entry goes to SKID.
- On pop with SKID full, SKID moves to OUT and SKID is cleared. A simultaneous accept is impossible in this case because ready=0.
- Pop and accept in the same cycle with SKID empty: the new entry replaces OUT, giving continuous 1 result/cycle throughput.
- Order is strictly FIFO. Tag, ImmExt and Illegal are stored together per entry.

## Timing

- Latency: 1 cycle from accept to o_immgen_valid when unstalled.
- Output stability: while o_immgen_valid=1 and i_immgen_ready=0, the ImmExt, Tag and Illegal outputs are held stable.
- Reset:
  - o_immgen_valid=0, o_immgen_ImmExt=0, o_immgen_Tag=0, o_immgen_Illegal=0.
  - SKID is invalidated and cleared.
  - o_immgen_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation: both entries are discarded in that cycle with no output pop. Inputs presented during reset are ignored.
- Full condition: both entries valid, so ready=0. The first pop restores ready=1 on the next cycle.
- Illegal results are not trapped here. They are delivered like any other result, and Illegal is registered alongside the data.

## Structure

- Package imm_pkg:
  - typedef enum logic [2:0] imm_src_e with IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_RSV.
  - localparam of legal XLEN values.
- Sub-module imm_format: purely combinational, parametrised by XLEN. Maps Instr/ImmSrc to {ImmExt, Illegal}.
- The top level holds only the 2-entry skid logic.

## Test plan

- **I and S formats, XLEN=32:** I-type 0xFFF00093 (addi x1,x0,-1) gives ImmExt 0xFFFFFFFF. S-type 0xFE112E23 (sw x1,-4(x2)) gives 0xFFFFFFFC. Each result appears 1 cycle after accept with its tag intact.
- **B, U and Z formats:** B-type 0xFE000CE3 (beq -8) gives 0xFFFFFFF8, and with XLEN=64 gives 0xFFFFFFFFFFFFFFF8. U-type 0x123452B7 gives 0x12345000. Z with Instr[19:15]=5'h1F gives 0x0000001F.
- **Illegal cases:** SH with Instr[25:20]=6'h21 at XLEN=32 gives ImmExt 0x1 and Illegal=1. The same input at XLEN=64 gives 0x21 and Illegal=0. ImmSrc=111 gives 0 and Illegal=1.
- **Backpressure:** with i_immgen_ready=0, offer tags 1, 2, 3 back-to-back. Tags 1 and 2 are accepted, then o_immgen_ready=0. Tag 3 is held until i_immgen_ready rises. Tags then emerge in order 1, 2, 3, with no loss or duplication.
- **Streaming:** with both sides ready for 8 cycles, exactly 8 results are output on consecutive cycles.
- **Reset mid-operation:** assert i_immgen_rst with both entries full. The next cycle shows o_immgen_valid=0, o_immgen_ready=1 and all outputs 0.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the decode-stage immediate generator.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_J   = 3'b011,
    IMM_U   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_src_e;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;

  function automatic bit xlen_is_legal(input int unsigned xlen);
    return (xlen == XLEN_32) || (xlen == XLEN_64);
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream (instruction) and downstream (immediate) handshake bundle.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
);
  logic              i_immgen_valid;
  logic              o_immgen_ready;
  logic [31:7]       i_immgen_Instr;
  imm_src_e          i_immgen_ImmSrc;
  logic [TAG_W-1:0]  i_immgen_Tag;
  logic              o_immgen_valid;
  logic              i_immgen_ready;
  logic [XLEN-1:0]   o_immgen_ImmExt;
  logic [TAG_W-1:0]  o_immgen_Tag;
  logic              o_immgen_Illegal;

  // Block side
  modport slave (
    input  i_immgen_valid, i_immgen_Instr, i_immgen_ImmSrc, i_immgen_Tag, i_immgen_ready,
    output o_immgen_ready, o_immgen_valid, o_immgen_ImmExt, o_immgen_Tag, o_immgen_Illegal
  );

  // Driver side (decode upstream + execute downstream)
  modport master (
    output i_immgen_valid, i_immgen_Instr, i_immgen_ImmSrc, i_immgen_Tag, i_immgen_ready,
    input  o_immgen_ready, o_immgen_valid, o_immgen_ImmExt, o_immgen_Tag, o_immgen_Illegal
  );
endinterface

// File: rtl/imm_gen_pipe_format.sv
// Combinational immediate extraction/extension for all RV32I/RV64I formats.
module imm_format
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_src_e        imm_src,
  output logic [XLEN-1:0] imm_ext,
  output logic            illegal
);

  // Decode the selected format; unlisted upper bits stay zero.
  always_comb begin
    imm_ext = '0;
    illegal = 1'b0;
    unique case (imm_src)
      IMM_I:  imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S:  imm_ext = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm_ext = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                         instr[30:25], instr[11:8], 1'b0};
      IMM_J:  imm_ext = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                         instr[20], instr[30:21], 1'b0};
      IMM_U: begin
        // Fill with the sign first so XLEN=32 needs no zero-width replication.
        imm_ext       = {XLEN{instr[31]}};
        imm_ext[31:0] = {instr[31:12], 12'b0};
      end
      IMM_Z:  imm_ext[4:0] = instr[19:15];
      IMM_SH: begin
        if (XLEN == XLEN_32) begin
          imm_ext[4:0] = instr[24:20];
          illegal      = instr[25];
        end else begin
          imm_ext[5:0] = instr[25:20];
        end
      end
      IMM_RSV: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (OUT + SKID).
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic          i_immgen_clk,
  input  logic          i_immgen_rst,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  imm;
    logic             illegal;
  } entry_t;

  entry_t          new_entry;
  entry_t          out_q;
  entry_t          skid_q;
  logic            out_valid;
  logic            skid_valid;
  logic            accept;
  logic            pop;
  logic [XLEN-1:0] fmt_imm;
  logic            fmt_illegal;

  imm_format #(.XLEN(XLEN)) u_format (
    .instr   (bus.i_immgen_Instr),
    .imm_src (bus.i_immgen_ImmSrc),
    .imm_ext (fmt_imm),
    .illegal (fmt_illegal)
  );

  // Handshake terms; ready depends only on registered SKID state.
  always_comb begin
    new_entry         = '0;
    new_entry.tag     = bus.i_immgen_Tag;
    new_entry.imm     = fmt_imm;
    new_entry.illegal = fmt_illegal;
    accept            = bus.i_immgen_valid & ~skid_valid;
    pop               = out_valid & bus.i_immgen_ready;
  end

  // FIFO-ordered OUT/SKID update; a pop with SKID full cannot coincide with accept.
  always_ff @(posedge i_immgen_clk) begin
    if (i_immgen_rst) begin
      out_valid  <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (pop && skid_valid) begin
      out_q      <= skid_q;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (accept && (!out_valid || pop)) begin
      out_q     <= new_entry;
      out_valid <= 1'b1;
    end else if (accept) begin
      skid_q     <= new_entry;
      skid_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

  // Drive outputs straight from registers.
  always_comb begin
    bus.o_immgen_ready   = ~skid_valid;
    bus.o_immgen_valid   = out_valid;
    bus.o_immgen_ImmExt  = out_q.imm;
    bus.o_immgen_Tag     = out_q.tag;
    bus.o_immgen_Illegal = out_q.illegal;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready;
  logic [31:0] in_instr;
  logic [2:0]  in_src;
  logic [31:0] in_tag;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) bus64 ();

  assign bus32.i_immgen_valid  = in_valid;
  assign bus32.i_immgen_ready  = in_ready;
  assign bus32.i_immgen_Instr  = in_instr[31:7];
  assign bus32.i_immgen_ImmSrc = imm_src_e'(in_src);
  assign bus32.i_immgen_Tag    = in_tag;
  assign bus64.i_immgen_valid  = in_valid;
  assign bus64.i_immgen_ready  = in_ready;
  assign bus64.i_immgen_Instr  = in_instr[31:7];
  assign bus64.i_immgen_ImmSrc = imm_src_e'(in_src);
  assign bus64.i_immgen_Tag    = in_tag;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_immgen_clk (clk),
    .i_immgen_rst (rst),
    .bus          (bus32)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_immgen_clk (clk),
    .i_immgen_rst (rst),
    .bus          (bus64)
  );

  typedef struct {
    logic [31:0] tag;
    logic [63:0] imm32;
    logic [63:0] imm64;
    logic        ill32;
    logic        ill64;
  } exp_t;

  exp_t        q[$];
  logic [31:0] popped[$];
  bit          track = 1'b0;
  int          errors = 0;
  int          checks = 0;

  // Reference: immediate value as a signed integer, truncated to the XLEN.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen, output logic ill);
    longint v;
    ill = 1'b0;
    case (src)
      3'd0: v = $signed(ins[31:20]);
      3'd1: v = $signed({ins[31:25], ins[11:7]});
      3'd2: v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      3'd3: v = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
      3'd4: v = longint'($signed(ins[31:12])) * 4096;
      3'd5: v = longint'(ins[19:15]);
      3'd6: begin
        if (xlen == 32) begin
          v   = longint'(ins[24:20]);
          ill = ins[25];
        end else begin
          v = longint'(ins[25:20]);
        end
      end
      default: begin
        v   = 0;
        ill = 1'b1;
      end
    endcase
    return (xlen == 32) ? {32'h0, v[31:0]} : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("valid32", {63'h0, bus32.o_immgen_valid}, {63'h0, q.size() > 0});
    chk("valid64", {63'h0, bus64.o_immgen_valid}, {63'h0, q.size() > 0});
    chk("ready32", {63'h0, bus32.o_immgen_ready}, {63'h0, q.size() < 2});
    chk("ready64", {63'h0, bus64.o_immgen_ready}, {63'h0, q.size() < 2});
    if (q.size() > 0) begin
      chk("imm32", {32'h0, bus32.o_immgen_ImmExt}, q[0].imm32);
      chk("imm64", bus64.o_immgen_ImmExt, q[0].imm64);
      chk("tag32", {32'h0, bus32.o_immgen_Tag}, {32'h0, q[0].tag});
      chk("tag64", {32'h0, bus64.o_immgen_Tag}, {32'h0, q[0].tag});
      chk("ill32", {63'h0, bus32.o_immgen_Illegal}, {63'h0, q[0].ill32});
      chk("ill64", {63'h0, bus64.o_immgen_Illegal}, {63'h0, q[0].ill64});
    end
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, {62'h0, bus32.o_immgen_valid, bus64.o_immgen_valid}, 64'h0);
    chk({name, "_ready"}, {62'h0, bus32.o_immgen_ready, bus64.o_immgen_ready}, 64'h3);
    chk({name, "_imm32"}, {32'h0, bus32.o_immgen_ImmExt}, 64'h0);
    chk({name, "_imm64"}, bus64.o_immgen_ImmExt, 64'h0);
    chk({name, "_tag"}, {bus32.o_immgen_Tag, bus64.o_immgen_Tag}, 64'h0);
    chk({name, "_ill"}, {62'h0, bus32.o_immgen_Illegal, bus64.o_immgen_Illegal}, 64'h0);
  endtask

  // One clock: predict handshake from model occupancy, advance model, compare.
  task automatic cycle();
    bit   acc, pop;
    exp_t e, d;
    acc = in_valid && !rst && (q.size() < 2);
    pop = in_ready && !rst && (q.size() > 0);
    if (pop && track) popped.push_back(bus32.o_immgen_Tag);
    if (acc) begin
      e.tag   = in_tag;
      e.imm32 = ref_imm(in_instr, in_src, 32, e.ill32);
      e.imm64 = ref_imm(in_instr, in_src, 64, e.ill64);
    end
    @(posedge clk);
    #1;
    if (rst) q.delete();
    else begin
      if (pop) d = q.pop_front();
      if (acc) q.push_back(e);
    end
    check_state();
  endtask

  logic [31:0] d_ins[8] = '{32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'hFF9FF0EF,
                            32'h123452B7, 32'h000F8073, 32'h02101013, 32'h00000000};
  logic [63:0] d_e32[8] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'hFFFFFFF8, 64'hFFFFFFF8,
                            64'h12345000, 64'h1F, 64'h1, 64'h0};
  logic [63:0] d_e64[8] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
                            64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFF8,
                            64'h12345000, 64'h1F, 64'h21, 64'h0};
  logic [7:0]  d_ill32 = 8'b1100_0000;
  logic [7:0]  d_ill64 = 8'b1000_0000;

  initial begin
    bit acc;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_ready = 1'b1;
    in_instr = 32'hFFF00093;
    in_src   = 3'd0;
    in_tag   = 32'hDEAD;
    cycle();
    cycle();
    chk_zero("reset");
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle();

    // Streaming: one result per cycle for 8 consecutive cycles.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = d_ins[i];
      in_src   = 3'(i);
      in_tag   = 32'(100 + i);
      cycle();
      chk("stream_valid", {63'h0, bus32.o_immgen_valid}, 64'h1);
      chk("stream_imm32", {32'h0, bus32.o_immgen_ImmExt}, d_e32[i]);
      chk("stream_imm64", bus64.o_immgen_ImmExt, d_e64[i]);
      chk("stream_tag", {32'h0, bus64.o_immgen_Tag}, 64'(100 + i));
      chk("stream_ill", {62'h0, bus32.o_immgen_Illegal, bus64.o_immgen_Illegal},
          {62'h0, d_ill32[i], d_ill64[i]});
    end
    in_valid = 1'b0;
    cycle();
    chk("stream_end", {63'h0, bus32.o_immgen_valid}, 64'h0);

    // Backpressure: tags 1,2 fill OUT+SKID, tag 3 waits for downstream.
    in_ready = 1'b0;
    popped.delete();
    track    = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1;
      in_instr = $urandom;
      in_src   = 3'($urandom_range(0, 7));
      in_tag   = 32'(t);
      cycle();
      if (t == 2) chk("bp_full_ready", {63'h0, bus32.o_immgen_ready}, 64'h0);
    end
    cycle();
    chk("bp_hold_tag", {32'h0, bus32.o_immgen_Tag}, 64'h1);
    in_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      acc = in_valid && (q.size() < 2);
      cycle();
      if (acc) in_valid = 1'b0;
    end
    track = 1'b0;
    chk("bp_count", 64'(popped.size()), 64'h3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < popped.size()) ? {32'h0, popped[i]} : 64'hFFFF, 64'(i + 1));

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 3) != 0);
      in_instr = $urandom;
      in_src   = 3'($urandom_range(0, 7));
      in_tag   = $urandom;
      cycle();
    end

    // Reset with both entries occupied.
    in_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    chk("pre_rst_ready", {63'h0, bus32.o_immgen_ready}, 64'h0);
    rst = 1'b1;
    cycle();
    chk_zero("midrst");
    rst      = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
